two_channel_request_queue: RTL and testbench
============================================

# two_channel_request_queue

Two independent FIFO queues that buffer incoming work items for two requesters and present non-empty status to the round-robin arbiter as its `requests` vector. The block sits directly upstream of the two-request round-robin arbiter. It consumes the arbiter's one-hot `grants` to pop the granted queue, and drives the popped item onto a single merged output. Together the pair forms a fair 2:1 stream merger.

## Interface
- `WIDTH`, default 8: data width of each work item.
- `DEPTH`, default 4: entries per queue; must be a power of two and ≥ 2.
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `in0_valid`  input  1  channel 0 push request.
- `in0_data`  input  WIDTH  channel 0 push data.
- `in0_ready`  output  1  channel 0 can accept; equals queue 0 not full.
- `in1_valid`, `in1_data`, `in1_ready`: same as channel 0, for queue 1.
- `requests`  output  2  bit i = queue i non-empty; feeds the arbiter.
- `grants`  input  2  one-hot grant from the arbiter; bit i pops queue i.
- `out_valid`  output  1  an item is being popped this cycle.
- `out_data`  output  WIDTH  head of the popped queue; 0 when `out_valid` = 0.
- `out_src`  output  1  index of the popped queue; 0 when `out_valid` = 0.
- `level0`, `level1`  output  $clog2(DEPTH)+1  current occupancy of each queue.
- `grant_err`  output  1  sticky error flag; set on an illegal grant, cleared only by `rst`.

## Operation
- Each queue is a circular buffer.
  - State: write pointer, read pointer and occupancy counter, each $clog2(DEPTH)+1 bits wide, so `level` can reach DEPTH.
  - Pointers wrap modulo DEPTH.
- Push on queue i: `ini_valid` && `ini_ready`.
  - Data is written at the write pointer; the write pointer increments.
  - `ini_valid` while full is dropped silently, with no state change. The source must hold it until `ini_ready` is seen.
- Pop on queue i: `grants` == one-hot bit i && `requests[i]`.
  - Read pointer increments.
  - `out_valid` = 1, `out_data` = head entry, `out_src` = i, all in the same cycle (combinational from `grants`).
- Grant to an empty queue: no pop, `out_valid` = 0, no error.
- `grants` == 2'b11: illegal.
  - No pop on either queue; `out_valid` = 0.
  - `grant_err` is set on the next edge and stays set.
- Simultaneous push and pop on the same queue: occupancy is unchanged and both pointers advance.
- Full queue: `ini_ready` = 0 even if a pop happens the same cycle. There is no full-bypass.
- Empty queue: a push and a grant in the same cycle do not pop. There is no flow-through; the item is first visible as `requests[i]` = 1 next cycle.
- The two queues are fully independent. Pushes on both channels plus a pop on one in the same cycle are all legal.

## Timing
- Reset values:
  - pointers and levels = 0
  - `requests` = 2'b00, `in0_ready` = `in1_ready` = 1
  - `out_valid` = 0, `out_data` = 0, `out_src` = 0, `grant_err` = 0
- Reset mid-operation: on the `rst` edge all queued items are discarded and the reset values hold the following cycle. `grants` is ignored while `rst` = 1.
- Push latency: a push accepted at edge N gives `requests[i]` = 1 and `level` updated from cycle N+1.
- Pop latency: the grant in cycle N returns data combinationally in cycle N. The head advances at edge N+1, and `requests[i]` falls at N+1 if the queue became empty.
- `requests` and `level` are registered-state outputs with no combinational path from `ini_valid` or `grants`. This prevents a loop through the combinational arbiter.
- `in_ready` depends only on registered occupancy.

## Test plan
- Reset, then idle: `requests` = 00, both `ready` = 1, `out_valid` = 0, `level0` = `level1` = 0, `grant_err` = 0.
- Push 0xA1, 0xA2 on ch0 and 0xB1 on ch1; then grants 01,10,01 on successive cycles:
  - `out_data` = A1 (`out_src` 0), B1 (`out_src` 1), A2 (`out_src` 0).
  - `requests` then = 00.
- Fill ch0 with 4 items (DEPTH=4):
  - `in0_ready` = 0 and `level0` = 4.
  - A 5th push 0xFF is dropped.
  - Four pops return items in order, never 0xFF.
  - Pointer wrap is verified with 6 more push/pop rounds.
- Push 0x55 to empty ch1 with `grants` = 10 in the same cycle: `out_valid` = 0 that cycle; next cycle `requests[1]` = 1 and `grants` = 10 gives `out_data` = 0x55.
- `grants` = 11 with both queues non-empty:
  - no pop; `levels` unchanged, `out_valid` = 0.
  - `grant_err` = 1 next cycle and stays 1 until `rst`.
- Load 3 items in each queue, assert `rst` for 1 cycle: `requests` = 00, `levels` = 0, `grant_err` = 0 afterward. Subsequent push and pop work from empty.

Source files
------------

// File: rtl/two_channel_request_queue.sv
// Two independent circular-buffer queues feeding a 2:1 round-robin arbiter;
// the one-hot grant pops the chosen queue and its head appears on a merged output.
module two_channel_request_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in0_valid,
  input  logic [WIDTH-1:0]           in0_data,
  output logic                       in0_ready,
  input  logic                       in1_valid,
  input  logic [WIDTH-1:0]           in1_data,
  output logic                       in1_ready,
  output logic [1:0]                 requests,
  input  logic [1:0]                 grants,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_src,
  output logic [$clog2(DEPTH):0]     level0,
  output logic [$clog2(DEPTH):0]     level1,
  output logic                       grant_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [2][DEPTH];
  logic [LW-1:0]    wptr [2];
  logic [LW-1:0]    rptr [2];
  logic [LW-1:0]    level [2];
  logic [WIDTH-1:0] din [2];
  logic [WIDTH-1:0] head [2];
  logic [1:0]       vld;
  logic [1:0]       rdy;
  logic [1:0]       push;
  logic [1:0]       pop;

  assign vld     = {in1_valid, in0_valid};
  assign din[0]  = in0_data;
  assign din[1]  = in1_data;

  // Ready and requests come only from registered occupancy, so there is no
  // combinational path from valid or grants back into the arbiter.
  always_comb begin
    rdy  = '0;
    push = '0;
    pop  = '0;
    for (int i = 0; i < 2; i++) begin
      rdy[i]      = (level[i] != LW'(DEPTH));
      requests[i] = (level[i] != '0);
      push[i]     = vld[i] && rdy[i];
      head[i]     = mem[i][rptr[i][AW-1:0]];
    end
    pop[0] = !rst && (grants == 2'b01) && requests[0];
    pop[1] = !rst && (grants == 2'b10) && requests[1];
  end

  assign in0_ready = rdy[0];
  assign in1_ready = rdy[1];
  assign level0    = level[0];
  assign level1    = level[1];

  always_comb begin
    out_valid = |pop;
    out_src   = pop[1];
    out_data  = '0;
    if (pop[0])
      out_data = head[0];
    else if (pop[1])
      out_data = head[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        level[i] <= '0;
      end
      grant_err <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) begin
          mem[i][wptr[i][AW-1:0]] <= din[i];
          wptr[i] <= wptr[i] + LW'(1);
        end
        if (pop[i])
          rptr[i] <= rptr[i] + LW'(1);
        if (push[i] && !pop[i])
          level[i] <= level[i] + LW'(1);
        else if (pop[i] && !push[i])
          level[i] <= level[i] - LW'(1);
      end
      if (grants == 2'b11)
        grant_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_two_channel_request_queue.sv
// Directed scenarios plus randomized traffic, checked against a queue-based
// model of the two channels.
module tb_two_channel_request_queue;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in0_valid, in1_valid;
  logic [WIDTH-1:0] in0_data, in1_data;
  logic             in0_ready, in1_ready;
  logic [1:0]       requests;
  logic [1:0]       grants;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic [2:0]       level0, level1;
  logic             grant_err;

  two_channel_request_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .requests(requests), .grants(grants),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .level0(level0), .level1(level1), .grant_err(grant_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference state: contents of each queue and the sticky error flag.
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  bit               m_err = 0;

  logic             obs_vld;
  logic [WIDTH-1:0] obs_dat;
  logic             obs_src;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check every output against the model,
  // then advance the model to the state after the coming edge.
  task automatic step(input bit r, input bit v0, input logic [7:0] d0,
                      input bit v1, input logic [7:0] d1, input logic [1:0] g);
    bit e_pop0, e_pop1, e_rdy0, e_rdy1;
    logic [7:0] e_dat;
    @(negedge clk);
    rst = r; in0_valid = v0; in0_data = d0; in1_valid = v1; in1_data = d1; grants = g;
    #1;
    e_rdy0 = q0.size() < DEPTH;
    e_rdy1 = q1.size() < DEPTH;
    e_pop0 = !r && g == 2'b01 && q0.size() > 0;
    e_pop1 = !r && g == 2'b10 && q1.size() > 0;
    e_dat  = e_pop0 ? q0[0] : (e_pop1 ? q1[0] : 8'h00);
    check("in0_ready", in0_ready, e_rdy0);
    check("in1_ready", in1_ready, e_rdy1);
    check("requests", requests, {q1.size() > 0, q0.size() > 0});
    check("level0", level0, q0.size());
    check("level1", level1, q1.size());
    check("out_valid", out_valid, e_pop0 | e_pop1);
    check("out_data", out_data, e_dat);
    check("out_src", out_src, e_pop1);
    check("grant_err", grant_err, m_err);
    obs_vld = out_valid; obs_dat = out_data; obs_src = out_src;
    if (r) begin
      q0.delete(); q1.delete(); m_err = 0;
    end else begin
      if (e_pop0) void'(q0.pop_front());
      if (e_pop1) void'(q1.pop_front());
      if (v0 && e_rdy0) q0.push_back(d0);
      if (v1 && e_rdy1) q1.push_back(d1);
      if (g == 2'b11) m_err = 1;
    end
  endtask

  task automatic idle();
    step(0, 0, 8'h00, 0, 8'h00, 2'b00);
  endtask

  initial begin
    rst = 1; in0_valid = 0; in1_valid = 0; in0_data = 0; in1_data = 0; grants = 0;
    repeat (2) @(posedge clk);

    // Reset then idle
    step(1, 0, 8'h00, 0, 8'h00, 2'b00);
    idle();
    check("idle_requests", requests, 2'b00);

    // Interleaved pops across channels
    step(0, 1, 8'hA1, 1, 8'hB1, 2'b00);
    step(0, 1, 8'hA2, 0, 8'h00, 2'b00);
    step(0, 0, 8'h00, 0, 8'h00, 2'b01);
    check("pop_a1", {obs_vld, obs_src, obs_dat}, {1'b1, 1'b0, 8'hA1});
    step(0, 0, 8'h00, 0, 8'h00, 2'b10);
    check("pop_b1", {obs_vld, obs_src, obs_dat}, {1'b1, 1'b1, 8'hB1});
    step(0, 0, 8'h00, 0, 8'h00, 2'b01);
    check("pop_a2", {obs_vld, obs_src, obs_dat}, {1'b1, 1'b0, 8'hA2});
    idle();
    check("drained_requests", requests, 2'b00);

    // Fill ch0, drop on full, drain in order, then wrap the pointers
    for (int i = 0; i < 4; i++) step(0, 1, 8'h10 + 8'(i), 0, 8'h00, 2'b00);
    idle();
    check("full_ready0", in0_ready, 1'b0);
    check("full_level0", level0, 3'd4);
    step(0, 1, 8'hFF, 0, 8'h00, 2'b01);
    check("full_pop0", obs_dat, 8'h10);
    check("full_ready_during_pop", in0_ready, 1'b0);
    for (int i = 1; i < 4; i++) begin
      step(0, 0, 8'h00, 0, 8'h00, 2'b01);
      check("drain_order", obs_dat, 8'h10 + 8'(i));
    end
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 8'h60 + 8'(i), 0, 8'h00, 2'b00);
      step(0, 0, 8'h00, 0, 8'h00, 2'b01);
      check("wrap_pop", obs_dat, 8'h60 + 8'(i));
    end

    // No flow-through on an empty queue
    step(0, 0, 8'h00, 1, 8'h55, 2'b10);
    check("no_flowthrough", obs_vld, 1'b0);
    step(0, 0, 8'h00, 0, 8'h00, 2'b10);
    check("pop_55", {obs_vld, obs_dat}, {1'b1, 8'h55});

    // Illegal grant: no pop, sticky error
    step(0, 1, 8'hC1, 1, 8'hD1, 2'b00);
    step(0, 0, 8'h00, 0, 8'h00, 2'b11);
    check("illegal_no_pop", obs_vld, 1'b0);
    idle();
    check("err_set", grant_err, 1'b1);
    check("illegal_levels", {level0, level1}, {3'd1, 3'd1});
    repeat (3) idle();
    check("err_sticky", grant_err, 1'b1);

    // Reset mid-operation with items queued
    for (int i = 0; i < 2; i++) step(0, 1, 8'h30 + 8'(i), 1, 8'h40 + 8'(i), 2'b00);
    step(1, 0, 8'h00, 0, 8'h00, 2'b01);
    idle();
    check("rst_state", {requests, level0, level1, grant_err}, 9'd0);
    step(0, 1, 8'h77, 0, 8'h00, 2'b00);
    step(0, 0, 8'h00, 0, 8'h00, 2'b01);
    check("post_rst_pop", obs_dat, 8'h77);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] g;
      int sel;
      sel = $urandom_range(0, 99);
      g = (sel < 40) ? 2'b01 : (sel < 80) ? 2'b10 : (sel < 98) ? 2'b00 : 2'b11;
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < 55, 8'($urandom),
           $urandom_range(0, 99) < 55, 8'($urandom), g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
